// File: rtl/pmem_responder_if.sv
// Line-transfer bus between a cache controller (master) and physical memory (slave).
// One whole line moves per request; pmem_resp closes each transfer.
interface pmem_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int LINE_WIDTH = 256
);
   logic                  pmem_read;
   logic                  pmem_write;
   logic [ADDR_WIDTH-1:0] pmem_address;
   logic [LINE_WIDTH-1:0] pmem_wdata;
   logic [LINE_WIDTH-1:0] pmem_rdata;
   logic                  pmem_resp;

   modport master (
      output pmem_read, pmem_write, pmem_address, pmem_wdata,
      input  pmem_rdata, pmem_resp
   );

   modport slave (
      input  pmem_read, pmem_write, pmem_address, pmem_wdata,
      output pmem_rdata, pmem_resp
   );
endinterface

// File: rtl/pmem_responder.sv
// Line-granular physical-memory responder: serves one whole-line read or write per
// request and answers with a single-cycle pmem_resp after a fixed latency.
module pmem_responder #(
   parameter int LATENCY    = 4,
   parameter int LINE_WIDTH = 256,
   parameter int INDEX_BITS = 8,
   parameter int ADDR_WIDTH = 32
) (
   input  logic   clk,
   input  logic   rst_n,
   pmem_if.slave  bus,
   output logic   protocol_err,
   output logic   busy
);

   localparam int OFF   = $clog2(LINE_WIDTH / 8);
   localparam int DEPTH = 1 << INDEX_BITS;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic [7:0]            cnt_q, cnt_d;
   logic                  op_write_q, op_write_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [LINE_WIDTH-1:0] wdata_q, wdata_d;
   logic [LINE_WIDTH-1:0] rdata_q, rdata_d;
   logic                  err_q, err_d;

   logic [LINE_WIDTH-1:0] mem [DEPTH];

   logic [INDEX_BITS-1:0] in_idx;
   logic [INDEX_BITS-1:0] lat_idx;
   logic [INDEX_BITS-1:0] rd_idx;
   logic                  rd_load;
   logic                  held_strobe;
   logic                  mem_we;

   assign in_idx      = bus.pmem_address[OFF +: INDEX_BITS];
   assign lat_idx     = addr_q[OFF +: INDEX_BITS];
   // A request that came in with both strobes runs as a write, so it is held by pmem_write.
   assign held_strobe = op_write_q ? bus.pmem_write : bus.pmem_read;
   assign mem_we      = (state_q == S_RESP) && op_write_q;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      op_write_d = op_write_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      err_d      = err_q;
      rd_load    = 1'b0;
      rd_idx     = lat_idx;

      case (state_q)
         S_IDLE: begin
            if (bus.pmem_read || bus.pmem_write) begin
               op_write_d = bus.pmem_write;
               addr_d     = bus.pmem_address;
               wdata_d    = bus.pmem_wdata;
               cnt_d      = 8'(LATENCY - 1);
               if (bus.pmem_read && bus.pmem_write) begin
                  err_d = 1'b1;
               end
               if (LATENCY == 1) begin
                  // Nothing is latched yet, so the read must index from the live address.
                  state_d = S_RESP;
                  rd_load = !bus.pmem_write;
                  rd_idx  = in_idx;
               end else begin
                  state_d = S_BUSY;
               end
            end
         end

         S_BUSY: begin
            if ((bus.pmem_address != addr_q) ||
                (op_write_q && (bus.pmem_wdata != wdata_q))) begin
               err_d = 1'b1;
            end
            if (!held_strobe) begin
               state_d = S_IDLE;
               err_d   = 1'b1;
            end else begin
               cnt_d = cnt_q - 8'd1;
               if (cnt_q == 8'd1) begin
                  state_d = S_RESP;
                  rd_load = !op_write_q;
               end
            end
         end

         S_RESP: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Read data is fetched on the edge entering RESP and held until the next read completes.
   always_comb begin
      rdata_d = rdata_q;
      if (rd_load) begin
         rdata_d = mem[rd_idx];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         cnt_q      <= 8'd0;
         op_write_q <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         rdata_q    <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         op_write_q <= op_write_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         rdata_q    <= rdata_d;
         err_q      <= err_d;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[lat_idx] <= wdata_q;
      end
   end

   assign bus.pmem_rdata = rdata_q;
   assign bus.pmem_resp  = (state_q == S_RESP);
   assign protocol_err   = err_q;
   assign busy           = (state_q != S_IDLE);

endmodule

// File: tb/tb_pmem_responder.sv
// Randomised bench for pmem_responder: a transaction-level timing/memory model predicts
// every output each cycle, plus literal checks for the directed scenarios.
module tb_pmem_responder;

   localparam int L     = 4;
   localparam int LW    = 256;
   localparam int IB    = 8;
   localparam int AW    = 32;
   localparam int DEPTH = 256;
   localparam int OFF   = 5;
   localparam int BIG   = 1 << 30;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic protocol_err;
   logic busy;

   always #5 clk = ~clk;

   pmem_if #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) bus ();

   pmem_responder #(
      .LATENCY(L), .LINE_WIDTH(LW), .INDEX_BITS(IB), .ADDR_WIDTH(AW)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .bus          (bus),
      .protocol_err (protocol_err),
      .busy         (busy)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Model: line contents plus the timing window of the request in flight.
   logic [LW-1:0] model_mem [DEPTH];
   logic [LW-1:0] exp_rdata = '0;
   int            req_cyc   = BIG;
   int            resp_cyc  = -1;
   int            busy_end  = -1;
   bit            req_write = 1'b0;
   int            req_idx   = 0;
   logic [LW-1:0] req_wdata = '0;
   int            err_from  = BIG;
   bit            chk_en    = 1'b0;

   int            n_pass  = 0;
   int            n_total = 0;
   int            last_resp_cyc = -1;
   int            prev_resp_cyc = -1;
   logic [LW-1:0] last_resp_rdata = '0;

   bit            e_busy, e_resp, e_err;

   task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
   endtask

   function automatic int imin(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   function automatic logic [LW-1:0] rnd_line();
      logic [LW-1:0] r;
      for (int i = 0; i < LW / 32; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   function automatic logic [AW-1:0] mk_addr(input int idx);
      logic [AW-1:0] a;
      logic [IB-1:0] ix;
      a  = $urandom;
      ix = idx[IB-1:0];
      a[OFF +: IB] = ix;
      return a;
   endfunction

   always @(negedge clk) begin
      if (chk_en) begin
         e_resp = (cyc == resp_cyc);
         e_busy = (cyc > req_cyc) && (cyc <= busy_end);
         e_err  = (cyc >= err_from);
         if (e_resp && !req_write) exp_rdata = model_mem[req_idx];
         check("resp",  {{(LW-1){1'b0}}, bus.pmem_resp}, {{(LW-1){1'b0}}, e_resp});
         check("busy",  {{(LW-1){1'b0}}, busy},          {{(LW-1){1'b0}}, e_busy});
         check("err",   {{(LW-1){1'b0}}, protocol_err},  {{(LW-1){1'b0}}, e_err});
         check("rdata", bus.pmem_rdata, exp_rdata);
         if (bus.pmem_resp) begin
            prev_resp_cyc   = last_resp_cyc;
            last_resp_cyc   = cyc;
            last_resp_rdata = bus.pmem_rdata;
         end
         if (e_resp && req_write) model_mem[req_idx] = req_wdata;
      end
   end

   // drop_at/chg_at are offsets from the accept cycle (0 = not used).
   task automatic req(input bit wr, input bit rd, input logic [AW-1:0] addr,
                      input logic [LW-1:0] wd, input int drop_at, input int chg_at,
                      output int t_start);
      int n;
      @(posedge clk); #1;
      t_start          = cyc;
      bus.pmem_read    = rd;
      bus.pmem_write   = wr;
      bus.pmem_address = addr;
      bus.pmem_wdata   = wd;
      req_cyc   = t_start;
      req_write = wr;
      req_idx   = int'(addr[OFF +: IB]);
      req_wdata = wd;
      if (rd && wr) err_from = imin(err_from, t_start + 1);
      if (drop_at > 0) begin
         resp_cyc = -1;
         busy_end = t_start + drop_at;
         err_from = imin(err_from, t_start + drop_at + 1);
         n = drop_at;
      end else begin
         resp_cyc = t_start + L;
         busy_end = t_start + L;
         n = L;
      end
      for (int k = 1; k <= n; k++) begin
         @(posedge clk); #1;
         if (k == chg_at) begin
            bus.pmem_address = bus.pmem_address ^ (32'd1 << OFF);
            err_from = imin(err_from, t_start + k + 1);
         end
         if (k == drop_at) begin
            bus.pmem_read  = 1'b0;
            bus.pmem_write = 1'b0;
         end
      end
      @(negedge clk); #1;
   endtask

   task automatic idle(input int n);
      @(posedge clk); #1;
      bus.pmem_read  = 1'b0;
      bus.pmem_write = 1'b0;
      repeat (n - 1) begin
         @(posedge clk); #1;
      end
   endtask

   initial begin
      int t, t1, saved, kind, idx, op;
      logic [LW-1:0] p1, p2, p3, p4, p5, p6, p7, pa5;
      p1  = {32{8'h11}};
      p2  = {32{8'h22}};
      p3  = {32{8'h33}};
      p4  = {32{8'h44}};
      p5  = {32{8'h55}};
      p6  = {32{8'h66}};
      p7  = {32{8'h77}};
      pa5 = {32{8'hA5}};

      bus.pmem_read    = 1'b0;
      bus.pmem_write   = 1'b0;
      bus.pmem_address = '0;
      bus.pmem_wdata   = '0;
      @(posedge clk); #1;
      chk_en = 1'b1;
      check("reset_busy", {{(LW-1){1'b0}}, busy}, '0);
      check("reset_resp", {{(LW-1){1'b0}}, bus.pmem_resp}, '0);
      check("reset_err",  {{(LW-1){1'b0}}, protocol_err}, '0);
      check("reset_rdata", bus.pmem_rdata, '0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      for (int i = 0; i < DEPTH; i++) begin
         model_mem[i] = rnd_line();
         req(1'b1, 1'b0, mk_addr(i), model_mem[i], 0, 0, t);
      end

      // Directed: write/read timing at address 0x40.
      req(1'b1, 1'b0, 32'h0000_0040, pa5, 0, 0, t1);
      check("t1_resp_lat", LW'(last_resp_cyc - t1), LW'(4));
      req(1'b0, 1'b1, 32'h0000_0040, '0, 0, 0, t);
      check("t2_resp_cyc", LW'(last_resp_cyc - t1), LW'(9));
      check("t2_rdata", last_resp_rdata, pa5);
      check("t2_err", {{(LW-1){1'b0}}, protocol_err}, '0);

      // Write-back then fill.
      req(1'b1, 1'b0, 32'h0000_00E0, p2, 0, 0, t);
      idle(2);
      req(1'b1, 1'b0, 32'h0000_0060, p1, 0, 0, t);
      req(1'b0, 1'b1, 32'h0000_00E0, '0, 0, 0, t);
      check("t3_gap", LW'(last_resp_cyc - prev_resp_cyc), LW'(L + 1));
      check("t3_rdata", last_resp_rdata, p2);

      // Aliasing through ignored upper address bits.
      req(1'b1, 1'b0, 32'h0000_2060, p3, 0, 0, t);
      req(1'b0, 1'b1, 32'h0000_0060, '0, 0, 0, t);
      check("t4_alias", last_resp_rdata, p3);

      // Violations.
      saved = last_resp_cyc;
      req(1'b0, 1'b1, 32'h0000_0040, '0, 2, 0, t);
      idle(2);
      check("t5_no_resp", LW'(last_resp_cyc), LW'(saved));
      check("t5_err", {{(LW-1){1'b0}}, protocol_err}, {{(LW-1){1'b0}}, 1'b1});
      check("t5_idle", {{(LW-1){1'b0}}, busy}, '0);
      req(1'b1, 1'b1, 32'h0000_0080, p4, 0, 0, t);
      req(1'b0, 1'b1, 32'h0000_0080, '0, 0, 0, t);
      check("t5_both", last_resp_rdata, p4);
      req(1'b1, 1'b0, 32'h0000_0140, p7, 0, 1, t);
      req(1'b0, 1'b1, 32'h0000_0140, '0, 0, 0, t);
      check("t5_latched_addr", last_resp_rdata, p7);

      // Reset in the middle of a write to index 9.
      req(1'b1, 1'b0, 32'h0000_0120, p6, 0, 0, t);
      @(posedge clk); #1;
      bus.pmem_write   = 1'b1;
      bus.pmem_read    = 1'b0;
      bus.pmem_address = 32'h0000_0120;
      bus.pmem_wdata   = p5;
      req_cyc = cyc; resp_cyc = cyc + L; busy_end = cyc + L;
      req_write = 1'b1; req_idx = 9; req_wdata = p5;
      repeat (2) begin
         @(posedge clk); #1;
      end
      rst_n = 1'b0;
      bus.pmem_write = 1'b0;
      req_cyc = BIG; resp_cyc = -1; busy_end = -1; exp_rdata = '0; err_from = BIG;
      #1;
      check("t6_rst_busy", {{(LW-1){1'b0}}, busy}, '0);
      check("t6_rst_err", {{(LW-1){1'b0}}, protocol_err}, '0);
      check("t6_rst_rdata", bus.pmem_rdata, '0);
      repeat (2) begin
         @(posedge clk); #1;
      end
      rst_n = 1'b1;
      req(1'b0, 1'b1, 32'h0000_0120, '0, 0, 0, t);
      check("t6_no_write", last_resp_rdata, p6);

      for (int n = 0; n < 300; n++) begin
         kind = $urandom_range(0, 9);
         idx  = $urandom_range(0, DEPTH - 1);
         op   = $urandom_range(0, 1);
         case (kind)
            0, 1, 2, 3: req(1'b1, 1'b0, mk_addr(idx), rnd_line(), 0, 0, t);
            4, 5, 6:    req(1'b0, 1'b1, mk_addr(idx), rnd_line(), 0, 0, t);
            7:          req(1'b1, 1'b1, mk_addr(idx), rnd_line(), 0, 0, t);
            8:          req(op[0], !op[0], mk_addr(idx), rnd_line(), $urandom_range(1, L - 1), 0, t);
            default:    req(op[0], !op[0], mk_addr(idx), rnd_line(), 0, $urandom_range(1, L - 1), t);
         endcase
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      end
      idle(3);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
